// File: rtl/instruction_loader_if.sv
// Byte-stream and memory-write-port bundle for the instruction loader.
// The master side is the loader; the slave side is the environment
// (byte source, instruction memory and debug unit).
interface instruction_loader_if #(
  parameter int PC_WIDTH = 9,
  parameter int NB_WIDTH = 32
);
  logic                i_start;
  logic [7:0]          i_rx_data;
  logic                i_rx_valid;
  logic                o_rx_ready;
  logic                o_write_enable;
  logic [PC_WIDTH-1:0] o_address;
  logic [NB_WIDTH-1:0] o_write_data;
  logic                o_busy;
  logic                o_done;
  logic                o_overflow;
  logic [PC_WIDTH:0]   o_word_count;

  modport master (
    input  i_start, i_rx_data, i_rx_valid,
    output o_rx_ready, o_write_enable, o_address, o_write_data,
           o_busy, o_done, o_overflow, o_word_count
  );

  modport slave (
    output i_start, i_rx_data, i_rx_valid,
    input  o_rx_ready, o_write_enable, o_address, o_write_data,
           o_busy, o_done, o_overflow, o_word_count
  );
endinterface

// File: rtl/instruction_loader.sv
// Packs a big-endian byte stream into 32-bit instruction words and writes
// them to sequential instruction memory addresses starting at 0. Loading
// ends on the HALT word (which is itself written) or when the last memory
// slot has been written, whichever comes first.
//
// state | meaning
// IDLE  | waiting for the first start pulse after reset
// RECV  | accepting bytes, assembling the current word
// WRITE | single-cycle write strobe for the assembled word
// DONE  | load finished, status held until the next start
module instruction_loader #(
  parameter int          PC_WIDTH  = 9,
  parameter int          NB_WIDTH  = 32,
  parameter logic [31:0] HALT_WORD = 32'hFFFFFFFF
) (
  input logic                 i_clk,
  input logic                 i_reset,
  instruction_loader_if.master bus
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  localparam logic [PC_WIDTH-1:0] LAST_ADDR = '1;

  state_t              state, state_next;
  logic [1:0]          byte_cnt, byte_cnt_next;
  logic [NB_WIDTH-1:0] word_buf, word_buf_next, packed_word;
  logic [NB_WIDTH-1:0] wdata_next;
  logic [PC_WIDTH-1:0] addr_next;
  logic [PC_WIDTH:0]   count_next;
  logic                overflow_next;
  logic                accept;

  assign accept      = (state == RECV) && bus.i_rx_valid && bus.o_rx_ready;
  assign packed_word = {word_buf[NB_WIDTH-9:0], bus.i_rx_data};

  // Next-state and next-register values; outputs are registered from these
  always_comb begin
    state_next    = state;
    byte_cnt_next = byte_cnt;
    word_buf_next = word_buf;
    wdata_next    = bus.o_write_data;
    addr_next     = bus.o_address;
    count_next    = bus.o_word_count;
    overflow_next = bus.o_overflow;
    case (state)
      IDLE, DONE: begin
        if (bus.i_start) begin
          state_next    = RECV;
          addr_next     = '0;
          count_next    = '0;
          byte_cnt_next = '0;
          word_buf_next = '0;
          overflow_next = 1'b0;
        end
      end
      RECV: begin
        if (accept) begin
          // shifting left leaves the first byte in the top lane
          word_buf_next = packed_word;
          byte_cnt_next = byte_cnt + 2'd1;
          if (byte_cnt == 2'd3) begin
            state_next = WRITE;
            wdata_next = packed_word;
            count_next = bus.o_word_count + (PC_WIDTH+1)'(1);
          end
        end
      end
      WRITE: begin
        if (bus.o_write_data == HALT_WORD) begin
          state_next    = DONE;
          overflow_next = 1'b0;
        end else if (bus.o_address == LAST_ADDR) begin
          // never wrap: the last slot ends the load as an overflow
          state_next    = DONE;
          overflow_next = 1'b1;
        end else begin
          state_next = RECV;
          addr_next  = bus.o_address + PC_WIDTH'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register plus registered outputs derived from the next state
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state              <= IDLE;
      byte_cnt           <= '0;
      word_buf           <= '0;
      bus.o_rx_ready     <= 1'b0;
      bus.o_write_enable <= 1'b0;
      bus.o_address      <= '0;
      bus.o_write_data   <= '0;
      bus.o_busy         <= 1'b0;
      bus.o_done         <= 1'b0;
      bus.o_overflow     <= 1'b0;
      bus.o_word_count   <= '0;
    end else begin
      state              <= state_next;
      byte_cnt           <= byte_cnt_next;
      word_buf           <= word_buf_next;
      bus.o_rx_ready     <= (state_next == RECV);
      bus.o_write_enable <= (state_next == WRITE);
      bus.o_address      <= addr_next;
      bus.o_write_data   <= wdata_next;
      bus.o_busy         <= (state_next == RECV) || (state_next == WRITE);
      bus.o_done         <= (state_next == DONE);
      bus.o_overflow     <= overflow_next;
      bus.o_word_count   <= count_next;
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Testbench for instruction_loader: a 512-word instance (a) and a 4-word
// instance (b), checked against a word-list model of the load rules.
module tb_instruction_loader;
  localparam logic [31:0] HALT = 32'hFFFFFFFF;

  typedef struct {
    logic [8:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instruction_loader_if #(.PC_WIDTH(9), .NB_WIDTH(32)) bus_a();
  instruction_loader_if #(.PC_WIDTH(2), .NB_WIDTH(32)) bus_b();

  instruction_loader #(.PC_WIDTH(9), .NB_WIDTH(32), .HALT_WORD(32'hFFFFFFFF)) dut_a (
    .i_clk(clk), .i_reset(rst), .bus(bus_a.master));
  instruction_loader #(.PC_WIDTH(2), .NB_WIDTH(32), .HALT_WORD(32'hFFFFFFFF)) dut_b (
    .i_clk(clk), .i_reset(rst), .bus(bus_b.master));

  int passes = 0;
  int total  = 0;
  wr_t cap_a[$];
  wr_t cap_b[$];
  wr_t exp_q[$];
  logic [31:0] words_q[$];
  logic exp_ovf;
  int   exp_count;
  int   dbl_a = 0;
  int   dbl_b = 0;
  logic prev_we_a = 1'b0;
  logic prev_we_b = 1'b0;

  // record every write strobe and count strobes lasting more than one cycle
  always @(negedge clk) begin
    if (bus_a.o_write_enable === 1'b1) cap_a.push_back('{bus_a.o_address, bus_a.o_write_data});
    if (bus_a.o_write_enable === 1'b1 && prev_we_a === 1'b1) dbl_a++;
    prev_we_a = bus_a.o_write_enable;
    if (bus_b.o_write_enable === 1'b1) cap_b.push_back('{9'(bus_b.o_address), bus_b.o_write_data});
    if (bus_b.o_write_enable === 1'b1 && prev_we_b === 1'b1) dbl_b++;
    prev_we_b = bus_b.o_write_enable;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic get_ready(input int sel);
    return (sel != 0) ? bus_b.o_rx_ready : bus_a.o_rx_ready;
  endfunction
  function automatic logic get_we(input int sel);
    return (sel != 0) ? bus_b.o_write_enable : bus_a.o_write_enable;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel != 0) ? bus_b.o_busy : bus_a.o_busy;
  endfunction
  function automatic logic get_done(input int sel);
    return (sel != 0) ? bus_b.o_done : bus_a.o_done;
  endfunction
  function automatic logic get_ovf(input int sel);
    return (sel != 0) ? bus_b.o_overflow : bus_a.o_overflow;
  endfunction
  function automatic logic [8:0] get_addr(input int sel);
    return (sel != 0) ? 9'(bus_b.o_address) : bus_a.o_address;
  endfunction
  function automatic logic [9:0] get_count(input int sel);
    return (sel != 0) ? 10'(bus_b.o_word_count) : bus_a.o_word_count;
  endfunction
  function automatic logic [31:0] get_data(input int sel);
    return (sel != 0) ? bus_b.o_write_data : bus_a.o_write_data;
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel != 0) bus_b.i_start = v; else bus_a.i_start = v;
  endtask
  task automatic set_valid(input int sel, input logic v, input logic [7:0] d);
    if (sel != 0) begin bus_b.i_rx_valid = v; bus_b.i_rx_data = d; end
    else begin bus_a.i_rx_valid = v; bus_a.i_rx_data = d; end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == HALT) w = 32'h1234_5678;
    return w;
  endfunction

  // expected writes: word i goes to address i; stop after HALT or a full memory
  task automatic model(input int depth);
    exp_q.delete();
    for (int i = 0; i < words_q.size() && i < depth; i++) begin
      exp_q.push_back('{9'(i), words_q[i]});
      if (words_q[i] == HALT) break;
    end
    exp_count = exp_q.size();
    exp_ovf   = (exp_count == depth) && (exp_q[exp_count-1].data != HALT);
  endtask

  // gap < 0 picks a random 0..3 idle cycles before each byte
  task automatic send_byte(input int sel, input logic [7:0] b, input int gap);
    int g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
    int n = 0;
    repeat (g) tick();
    while (get_ready(sel) !== 1'b1 && n < 64) begin tick(); n++; end
    check("rx_ready_wait", 64'(get_ready(sel)), 64'd1);
    set_valid(sel, 1'b1, b);
    tick();
    set_valid(sel, 1'b0, 8'h00);
  endtask

  task automatic send_word(input int sel, input logic [31:0] w, input int gap);
    send_byte(sel, w[31:24], gap);
    send_byte(sel, w[23:16], gap);
    send_byte(sel, w[15:8],  gap);
    send_byte(sel, w[7:0],   gap);
  endtask

  task automatic start_load(input int sel, input string tag);
    if (sel != 0) begin cap_b.delete(); dbl_b = 0; end
    else begin cap_a.delete(); dbl_a = 0; end
    set_start(sel, 1'b1);
    tick();
    set_start(sel, 1'b0);
    check({tag, "_start_done"}, 64'(get_done(sel)), 64'd0);
    check({tag, "_start_addr"}, 64'(get_addr(sel)), 64'd0);
    check({tag, "_start_busy"}, 64'(get_busy(sel)), 64'd1);
  endtask

  task automatic finish_check(input int sel, input string tag);
    int n = 0;
    wr_t got[$];
    model((sel != 0) ? 4 : 512);
    while (get_done(sel) !== 1'b1 && n < 200) begin tick(); n++; end
    check({tag, "_done"},     64'(get_done(sel)),  64'd1);
    check({tag, "_busy"},     64'(get_busy(sel)),  64'd0);
    check({tag, "_overflow"}, 64'(get_ovf(sel)),   64'(exp_ovf));
    check({tag, "_count"},    64'(get_count(sel)), 64'(exp_count));
    check({tag, "_last_addr"}, 64'(get_addr(sel)), 64'(exp_count - 1));
    if (sel != 0) got = cap_b; else got = cap_a;
    check({tag, "_nwrites"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      check({tag, "_addr"}, 64'(got[i].addr), 64'(exp_q[i].addr));
      check({tag, "_data"}, 64'(got[i].data), 64'(exp_q[i].data));
    end
    check({tag, "_strobe_len"}, 64'((sel != 0) ? dbl_b : dbl_a), 64'd0);
  endtask

  task automatic run_load(input int sel, input int gap, input string tag);
    int depth = (sel != 0) ? 4 : 512;
    start_load(sel, tag);
    model(depth);
    for (int i = 0; i < exp_count; i++) send_word(sel, exp_q[i].data, gap);
    finish_check(sel, tag);
  endtask

  task automatic check_reset_vals(input int sel, input string tag);
    check({tag, "_ready"}, 64'(get_ready(sel)), 64'd0);
    check({tag, "_we"},    64'(get_we(sel)),    64'd0);
    check({tag, "_busy"},  64'(get_busy(sel)),  64'd0);
    check({tag, "_done"},  64'(get_done(sel)),  64'd0);
    check({tag, "_ovf"},   64'(get_ovf(sel)),   64'd0);
    check({tag, "_addr"},  64'(get_addr(sel)),  64'd0);
    check({tag, "_data"},  64'(get_data(sel)),  64'd0);
    check({tag, "_count"}, 64'(get_count(sel)), 64'd0);
  endtask

  initial begin
    logic [31:0] w;
    rst = 1'b1;
    set_start(0, 1'b0); set_start(1, 1'b0);
    set_valid(0, 1'b0, 8'h00); set_valid(1, 1'b0, 8'h00);
    repeat (3) tick();
    rst = 1'b0;
    check_reset_vals(0, "reset_a");
    check_reset_vals(1, "reset_b");

    // directed program, back-to-back bytes
    words_q = '{32'h2001_0005, HALT};
    run_load(0, 0, "basic");

    // same program with three idle cycles before every byte
    run_load(0, 3, "gaps");

    // random program with random gaps
    words_q.delete();
    for (int i = 0; i < 6; i++) words_q.push_back(rand_word());
    words_q.push_back(HALT);
    run_load(0, -1, "random");

    // byte offered during the write cycle must be dropped
    words_q = '{rand_word(), rand_word(), HALT};
    start_load(0, "drop");
    send_word(0, words_q[0], 0);
    check("drop_we_in_write", 64'(get_we(0)), 64'd1);
    check("drop_ready_in_write", 64'(get_ready(0)), 64'd0);
    set_valid(0, 1'b1, 8'hAA);
    tick();
    set_valid(0, 1'b0, 8'h00);
    send_word(0, words_q[1], 0);
    send_word(0, words_q[2], 0);
    finish_check(0, "drop");

    // start pulse in the middle of a word is ignored
    w = rand_word();
    words_q = '{w, HALT};
    start_load(0, "midstart");
    send_byte(0, w[31:24], 0);
    send_byte(0, w[23:16], 0);
    set_start(0, 1'b1);
    tick();
    set_start(0, 1'b0);
    check("midstart_busy", 64'(get_busy(0)), 64'd1);
    send_byte(0, w[15:8], 0);
    send_byte(0, w[7:0], 0);
    send_word(0, HALT, 0);
    finish_check(0, "midstart");

    // reset after two bytes: nothing written, next load restarts at 0
    start_load(0, "rstmid");
    send_byte(0, 8'h11, 0);
    send_byte(0, 8'h22, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_vals(0, "rstmid");
    check("rstmid_nowrite", 64'(cap_a.size()), 64'd0);
    w = rand_word();
    words_q = '{w, HALT};
    start_load(0, "after_rst");
    send_word(0, w, 0);
    send_word(0, HALT, 0);
    finish_check(0, "after_rst");

    // reset during the write cycle drops the strobe next cycle
    start_load(0, "rstwr");
    send_word(0, rand_word(), 0);
    check("rstwr_we_before", 64'(get_we(0)), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstwr_we_after", 64'(get_we(0)), 64'd0);
    check("rstwr_busy_after", 64'(get_busy(0)), 64'd0);

    // 4-word memory filled without HALT: overflow, no fifth write
    words_q.delete();
    for (int i = 0; i < 5; i++) words_q.push_back(rand_word());
    run_load(1, -1, "full");
    for (int i = 0; i < 8; i++) begin
      set_valid(1, 1'b1, 8'($urandom));
      tick();
    end
    set_valid(1, 1'b0, 8'h00);
    check("full_no_extra_write", 64'(cap_b.size()), 64'd4);
    check("full_still_done", 64'(get_done(1)), 64'd1);

    // HALT in the last slot is a normal end, not an overflow
    words_q = '{rand_word(), rand_word(), rand_word(), HALT};
    run_load(1, 0, "halt_last");

    // HALT early in the small memory
    words_q = '{rand_word(), HALT};
    run_load(1, -1, "halt_early");

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
